imem_loader: RTL

Program-load front end for the RISC-V pipeline top. Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and drives the pipeline's `address`/`instruction` load port one word per write cycle. When the announced word count has been written, it raises `start` to release the core from load mode into execution. The debug readout path (`check_address`/`DataOrReg`) is untouched.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the byte-stream handshake and the pipeline word-load port that
//   pass between a program source, the loader and the pipeline top.
//   Signals:
//     byte_valid  - source has a stream byte on byte_data
//     byte_data   - stream byte, little-endian within each word
//     byte_ready  - loader will take the byte at the next rising edge
//     wr_en       - address/instruction carry a word to be written
//     address     - byte address of the word being written
//     instruction - assembled 32-bit word
//   Modports:
//     master - host / pipeline side (drives the stream, receives writes)
//     slave  - loader side
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] instruction;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, address, instruction
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, address, instruction
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Program-load front end for the pipeline top. Receives a two-byte word
//   count N followed by 4*N little-endian instruction bytes, writes each
//   assembled word to the pipeline load port, then raises start.
//   Ports:
//     clk          - system clock, rising edge
//     rst_n        - asynchronous active-low reset
//     load_req     - one-cycle pulse that opens a new load session
//     bus          - stream handshake and word-load port (slave view)
//     start        - pipeline run enable, high only in RUN
//     busy         - a load session is in progress
//     err          - sticky flag for an out-of-range word count
//     words_loaded - words written during the current session
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  imem_loader_if.slave  bus,
  output logic          start,
  output logic          busy,
  output logic          err,
  output logic [15:0]   words_loaded
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA, WRITE, RUN, ERR
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [1:0]  lane;
  logic [23:0] word_buf;

  logic        xfer;
  logic        restart;
  logic [15:0] n_hdr;
  logic [15:0] words_next;

  assign xfer       = bus.byte_valid && bus.byte_ready;
  assign n_hdr      = {bus.byte_data, n_lo};
  assign words_next = words_loaded + 16'd1;
  // load_req only counts in the non-busy states; a running session cannot be aborted
  assign restart    = load_req && (state == IDLE || state == RUN || state == ERR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, RUN, ERR: if (load_req) next_state = HDR0;
      HDR0:           if (xfer) next_state = HDR1;
      HDR1: begin
        if (xfer) begin
          if (n_hdr == 16'd0 || n_hdr > MAX_N) next_state = ERR;
          else                                 next_state = DATA;
        end
      end
      DATA:           if (xfer && lane == 2'd3) next_state = WRITE;
      WRITE:          next_state = (words_next == n_words) ? RUN : DATA;
      default:        next_state = IDLE;
    endcase
  end

  // Decoded outputs
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.wr_en      = 1'b0;
    busy           = 1'b0;
    case (state)
      HDR0, HDR1, DATA: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
      end
      WRITE: begin
        bus.wr_en = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: header capture, word assembly, write port and status flags.
  // start/err are registered from next_state so they track RUN/ERR exactly
  // without decode glitches. address/instruction are loaded on the lane-3
  // transfer so they are valid throughout WRITE and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lo            <= '0;
      n_words         <= '0;
      lane            <= '0;
      word_buf        <= '0;
      words_loaded    <= '0;
      bus.address     <= '0;
      bus.instruction <= '0;
      start           <= 1'b0;
      err             <= 1'b0;
    end else begin
      start <= (next_state == RUN);
      err   <= (next_state == ERR);
      if (restart) begin
        words_loaded <= '0;
        lane         <= '0;
      end
      if (state == HDR0 && xfer) n_lo <= bus.byte_data;
      if (state == HDR1 && xfer) n_words <= n_hdr;
      if (state == DATA && xfer) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0: word_buf[7:0]   <= bus.byte_data;
          2'd1: word_buf[15:8]  <= bus.byte_data;
          2'd2: word_buf[23:16] <= bus.byte_data;
          default: begin
            bus.instruction <= {bus.byte_data, word_buf};
            bus.address     <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
          end
        endcase
      end
      if (state == WRITE) words_loaded <= words_next;
    end
  end

endmodule
